// File: rtl/nlfsr_tap_enumerator_if.sv
// nlfsr_tap_enumerator_if: tester-facing candidate bus plus the found-candidate
// valid/ready stream toward the host-link FIFO.
// master = enumerator side, slave = tester / host-link side.
interface nlfsr_tap_enumerator_if #(
  parameter int NUM_OF_TAPS = 6
);
  localparam int W = NUM_OF_TAPS * 8;

  logic         tst_res;
  logic         tst_ena;
  logic [W-1:0] co_buf;
  logic         tst_found;
  logic         tst_failure;

  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output tst_res, tst_ena, co_buf, out_data, out_valid,
    input  tst_found, tst_failure, out_ready
  );

  modport slave (
    input  tst_res, tst_ena, co_buf, out_data, out_valid,
    output tst_found, tst_failure, out_ready
  );
endinterface

// File: rtl/nlfsr_tap_enumerator.sv
// nlfsr_tap_enumerator: odometer over candidate tap tuples for the NLFSR period
// tester. Each valid tuple is loaded onto co_buf, the tester is reset for one
// cycle and then enabled until it flags found or failure; found tuples are
// streamed out on a valid/ready handshake.
// Build option: define NLFSR_ENUM_WATCHDOG_EN to add a RUN-cycle watchdog and
// the sticky wdog_hit output.
//
//  state  | meaning
//  IDLE   | waiting for start, tester held in reset
//  LOAD   | screen current tuple, skip invalid ones at one per cycle
//  RST    | single tester reset cycle with the candidate on co_buf
//  RUN    | tester enabled, waiting for found / failure
//  REPORT | found candidate offered on out_data until accepted
//  NEXT   | step the odometer or finish on the last tuple
//  DONE   | enumeration complete, done held until start or res
module nlfsr_tap_enumerator #(
  parameter int SIZE        = 24,
  parameter int NUM_OF_TAPS = 6,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  nlfsr_tap_enumerator_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       cand_cnt,
  output logic [CNT_W-1:0]       found_cnt
`ifdef NLFSR_ENUM_WATCHDOG_EN
  ,
  output logic                   wdog_hit
`endif
);

  localparam int         W     = NUM_OF_TAPS * 8;
  localparam logic [7:0] DMAX  = 8'(SIZE - 1);
  localparam logic [W-1:0] FIRST = {NUM_OF_TAPS{8'd1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RST    = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     tup_q, tup_nxt;
  logic [W-1:0]     out_data_q;
  logic [CNT_W-1:0] cand_cnt_q, found_cnt_q;
  logic             run_first_q;

  logic             tuple_ok, tup_last, carry;
  logic             do_init, do_adv, cand_inc, found_inc, capture;
  logic             flag_seen;

`ifdef NLFSR_ENUM_WATCHDOG_EN
  localparam int             WD_W    = SIZE + 2;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((2 ** SIZE) + 7);
  logic [WD_W-1:0] wd_cnt_q;
  logic            wdog_q;
  logic            wd_abort;
`endif

  // Tuple screening: AND-pair ordered, linear taps strictly increasing.
  always_comb begin
    tuple_ok = (tup_q[7:0] < tup_q[15:8]);
    for (int j = 3; j < NUM_OF_TAPS; j++) begin
      if (tup_q[j*8-1 -: 8] >= tup_q[(j+1)*8-1 -: 8]) tuple_ok = 1'b0;
    end
  end

  // Last tuple detect: every digit at SIZE-1.
  always_comb begin
    tup_last = 1'b1;
    for (int j = 1; j <= NUM_OF_TAPS; j++) begin
      if (tup_q[j*8-1 -: 8] != DMAX) tup_last = 1'b0;
    end
  end

  // Odometer step: highest index is the fastest digit, carries ripple toward t1.
  always_comb begin
    tup_nxt = tup_q;
    carry   = 1'b1;
    for (int j = NUM_OF_TAPS; j >= 1; j--) begin
      if (carry) begin
        if (tup_q[j*8-1 -: 8] == DMAX) begin
          tup_nxt[j*8-1 -: 8] = 8'd1;
        end else begin
          tup_nxt[j*8-1 -: 8] = tup_q[j*8-1 -: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // The tester's flags clear on its reset, so the first RUN cycle is blind.
  assign flag_seen = !run_first_q && (bus.tst_found || bus.tst_failure);

  // State register.
  always_ff @(posedge clk) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_d   = state_q;
    do_init   = 1'b0;
    do_adv    = 1'b0;
    cand_inc  = 1'b0;
    found_inc = 1'b0;
    capture   = 1'b0;
`ifdef NLFSR_ENUM_WATCHDOG_EN
    wd_abort  = 1'b0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          do_init = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tuple_ok)      state_d = RST;
        else if (tup_last) state_d = DONE;
        else               do_adv  = 1'b1;
      end
      RST: state_d = RUN;
      RUN: begin
        if (flag_seen) begin
          cand_inc = 1'b1;
          if (bus.tst_found) begin
            capture = 1'b1;
            state_d = REPORT;
          end else begin
            state_d = NEXT;
          end
        end
`ifdef NLFSR_ENUM_WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          cand_inc = 1'b1;
          wd_abort = 1'b1;
          state_d  = NEXT;
        end
`endif
      end
      REPORT: begin
        if (bus.out_ready) begin
          found_inc = 1'b1;
          state_d   = NEXT;
        end
      end
      NEXT: begin
        if (tup_last) begin
          state_d = DONE;
        end else begin
          do_adv  = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Candidate tuple, captured report data, first-RUN-cycle marker.
  always_ff @(posedge clk) begin
    if (res) begin
      tup_q       <= FIRST;
      out_data_q  <= '0;
      run_first_q <= 1'b0;
    end else begin
      if (do_init)     tup_q <= FIRST;
      else if (do_adv) tup_q <= tup_nxt;
      if (capture) out_data_q <= tup_q;
      run_first_q <= (state_q == RST);
    end
  end

  // Saturating statistics counters, cleared on each new enumeration.
  always_ff @(posedge clk) begin
    if (res || do_init) begin
      cand_cnt_q  <= '0;
      found_cnt_q <= '0;
    end else begin
      if (cand_inc && (cand_cnt_q != '1))   cand_cnt_q  <= cand_cnt_q + CNT_W'(1);
      if (found_inc && (found_cnt_q != '1)) found_cnt_q <= found_cnt_q + CNT_W'(1);
    end
  end

`ifdef NLFSR_ENUM_WATCHDOG_EN
  // RUN-cycle watchdog: restarts on each tester reset, sticky hit flag.
  always_ff @(posedge clk) begin
    if (res || do_init) begin
      wd_cnt_q <= '0;
      wdog_q   <= 1'b0;
    end else begin
      if (state_q == RST)      wd_cnt_q <= '0;
      else if (state_q == RUN) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (wd_abort) wdog_q <= 1'b1;
    end
  end

  assign wdog_hit = wdog_q;
`endif

  // Moore outputs: tester held in reset everywhere except RUN.
  always_comb begin
    bus.tst_res   = (state_q != RUN);
    bus.tst_ena   = (state_q == RUN);
    bus.co_buf    = tup_q;
    bus.out_valid = (state_q == REPORT);
    bus.out_data  = out_data_q;
    busy          = (state_q != IDLE) && (state_q != DONE);
    done          = (state_q == DONE);
    cand_cnt      = cand_cnt_q;
    found_cnt     = found_cnt_q;
  end

endmodule
